// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush request and pipeline-control bundle for pipeline_stall_ctrl.
// slave = controller side, master = pipeline/top-level side.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard_Detected;
    logic             branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             freeze_id_exe;
    logic             freeze_exe_mem;
    logic             bubble_mem_wb;
    logic             flush_if_id;
    logic             bubble_id_exe;
    logic             mem_busy;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] hazard_stalls;

    modport slave (
        input  hazard_Detected, branch_taken, mem_access, mem_ready,
        output freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
        output bubble_mem_wb, flush_if_id, bubble_id_exe,
        output mem_busy, timeout_err, stall_cycles, hazard_stalls
    );

    modport master (
        output hazard_Detected, branch_taken, mem_access, mem_ready,
        input  freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
        input  bubble_mem_wb, flush_if_id, bubble_id_exe,
        input  mem_busy, timeout_err, stall_cycles, hazard_stalls
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush arbiter with memory-wait FSM and timeout watchdog.
// Define STALL_PERF_CNT_EN to add saturating stall performance counters.
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                rst,
    pipeline_stall_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            mem_busy_q, mem_busy_d;
    logic            timeout_err_q, timeout_err_d;

    logic mem_wait_now;
    logic hazard_win;
    logic f_pc, f_if_id, f_id_exe, f_exe_mem;
    logic b_mem_wb, fl_if_id, b_id_exe;

    assign mem_wait_now = bus.mem_access & ~bus.mem_ready;

    // Memory wait outranks branch, branch outranks hazard.
    always_comb begin
        f_pc       = 1'b0;
        f_if_id    = 1'b0;
        f_id_exe   = 1'b0;
        f_exe_mem  = 1'b0;
        b_mem_wb   = 1'b0;
        fl_if_id   = 1'b0;
        b_id_exe   = 1'b0;
        hazard_win = 1'b0;
        if (mem_wait_now) begin
            f_pc      = 1'b1;
            f_if_id   = 1'b1;
            f_id_exe  = 1'b1;
            f_exe_mem = 1'b1;
            b_mem_wb  = 1'b1;
        end else if (bus.branch_taken) begin
            fl_if_id = 1'b1;
            b_id_exe = 1'b1;
        end else if (bus.hazard_Detected) begin
            f_pc       = 1'b1;
            f_if_id    = 1'b1;
            b_id_exe   = 1'b1;
            hazard_win = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wdog_d        = '0;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait_now) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (!mem_wait_now) state_d = RUN;
                wdog_d = (wdog_q == TO_LIM) ? wdog_q : wdog_q + 1'b1;
                if (wdog_d == TO_LIM) timeout_err_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
        mem_busy_d = (state_d == MEM_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wdog_q        <= '0;
            mem_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            mem_busy_q    <= mem_busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.freeze_pc      = f_pc;
    assign bus.freeze_if_id   = f_if_id;
    assign bus.freeze_id_exe  = f_id_exe;
    assign bus.freeze_exe_mem = f_exe_mem;
    assign bus.bubble_mem_wb  = b_mem_wb;
    assign bus.flush_if_id    = fl_if_id;
    assign bus.bubble_id_exe  = b_id_exe;
    assign bus.mem_busy       = mem_busy_q;
    assign bus.timeout_err    = timeout_err_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] hazard_stalls_q, hazard_stalls_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        hazard_stalls_d = hazard_stalls_q;
        if (f_pc && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (hazard_win && (hazard_stalls_q != '1))
            hazard_stalls_d = hazard_stalls_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q  <= '0;
            hazard_stalls_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            hazard_stalls_q <= hazard_stalls_d;
        end
    end

    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.hazard_stalls = hazard_stalls_q;
`else
    assign bus.stall_cycles  = '0;
    assign bus.hazard_stalls = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (TIMEOUT=4, CNT_W=4).
// Control vector order: pc,if_id,id_exe,exe_mem,mem_wb,flush,bub_id_exe,busy,terr.
module tb_pipeline_stall_ctrl;

    localparam logic [8:0] IDLE   = 9'b000000000;
    localparam logic [8:0] HAZ    = 9'b110000100;
    localparam logic [8:0] MEMF   = 9'b111110000;
    localparam logic [8:0] BRN    = 9'b000001100;
    localparam logic [8:0] BUSY   = 9'b000000010;
    localparam logic [8:0] TERR   = 9'b000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_stall_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_stall_ctrl #(
        .TIMEOUT(4),
        .TO_W   (8),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl();
        return {bus.freeze_pc, bus.freeze_if_id, bus.freeze_id_exe,
                bus.freeze_exe_mem, bus.bubble_mem_wb, bus.flush_if_id,
                bus.bubble_id_exe, bus.mem_busy, bus.timeout_err};
    endfunction

    function automatic logic [31:0] ecnt(input logic [31:0] v);
`ifdef STALL_PERF_CNT_EN
        return v;
`else
        return (v == 32'd0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic h, input logic b, input logic a,
                       input logic r);
        bus.hazard_Detected = h;
        bus.branch_taken    = b;
        bus.mem_access      = a;
        bus.mem_ready       = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        drv(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0);
        chk("reset_ctrl", 32'(ctrl()), 32'(IDLE));
        chk("reset_stall_cnt", 32'(bus.stall_cycles), 32'd0);
        chk("reset_haz_cnt", 32'(bus.hazard_stalls), 32'd0);
        #10;
        rst = 1'b0;
        tick();

        // Hazard only, two cycles
        drv(1, 0, 0, 0);
        chk("haz_c1", 32'(ctrl()), 32'(HAZ));
        tick();
        chk("haz_c2", 32'(ctrl()), 32'(HAZ));
        tick();
        drv(0, 0, 0, 0);
        chk("haz_done", 32'(ctrl()), 32'(IDLE));
        chk("haz_hz_cnt", 32'(bus.hazard_stalls), ecnt(2));
        chk("haz_st_cnt", 32'(bus.stall_cycles), ecnt(2));

        // Access and ready together in RUN: no stall
        drv(0, 0, 1, 1);
        chk("hit_ctrl", 32'(ctrl()), 32'(IDLE));
        tick();
        chk("hit_busy", 32'(ctrl()), 32'(IDLE));

        // Load miss: ready low 5 cycles, watchdog trips on 4th MEM_WAIT
        do_rst();
        drv(0, 0, 1, 0);
        chk("miss_c1", 32'(ctrl()), 32'(MEMF));
        tick();
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("miss_c%0d", i), 32'(ctrl()), 32'(MEMF | BUSY));
            tick();
        end
        drv(0, 0, 1, 1);
        chk("miss_ready", 32'(ctrl()), 32'(BUSY | TERR));
        tick();
        drv(0, 0, 0, 0);
        chk("miss_after", 32'(ctrl()), 32'(TERR));
        chk("miss_st_cnt", 32'(bus.stall_cycles), ecnt(5));
        chk("miss_hz_cnt", 32'(bus.hazard_stalls), ecnt(0));

        // Watchdog: 10 cycles of wait
        do_rst();
        chk("wd_cleared", 32'(ctrl()), 32'(IDLE));
        drv(0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("wd_c%0d", i), 32'(ctrl()),
                32'(MEMF | (i > 1 ? BUSY : IDLE) | (i >= 6 ? TERR : IDLE)));
            tick();
        end
        drv(0, 0, 1, 1);
        chk("wd_ready", 32'(ctrl()), 32'(BUSY | TERR));
        tick();
        drv(0, 0, 0, 0);
        chk("wd_sticky", 32'(ctrl()), 32'(TERR));
        chk("wd_st_cnt", 32'(bus.stall_cycles), ecnt(10));
        tick();
        chk("wd_sticky2", 32'(ctrl()), 32'(TERR));

        // Reset while in MEM_WAIT
        drv(0, 0, 1, 0);
        tick();
        chk("rmw_busy", 32'(ctrl()), 32'(MEMF | BUSY | TERR));
        rst = 1'b1;
        #1;
        chk("rmw_in_rst", 32'(ctrl()), 32'(MEMF));
        rst = 1'b0;
        #1;
        chk("rmw_release", 32'(ctrl()), 32'(MEMF));
        tick();
        chk("rmw_rewait", 32'(ctrl()), 32'(MEMF | BUSY));
        drv(0, 0, 0, 0);
        chk("rmw_abort", 32'(ctrl()), 32'(BUSY));
        tick();
        chk("rmw_run", 32'(ctrl()), 32'(IDLE));

        // Priority clash
        do_rst();
        drv(1, 1, 1, 0);
        chk("clash_mem", 32'(ctrl()), 32'(MEMF));
        tick();
        drv(1, 1, 1, 1);
        chk("clash_branch", 32'(ctrl()), 32'(BRN | BUSY));
        tick();
        drv(0, 0, 0, 0);
        chk("clash_idle", 32'(ctrl()), 32'(IDLE));
        chk("clash_st_cnt", 32'(bus.stall_cycles), ecnt(1));
        chk("clash_hz_cnt", 32'(bus.hazard_stalls), ecnt(0));

        // Branch beats hazard with no memory wait
        drv(1, 1, 0, 0);
        chk("br_over_haz", 32'(ctrl()), 32'(BRN));
        tick();
        drv(0, 0, 0, 0);
        chk("br_hz_cnt", 32'(bus.hazard_stalls), ecnt(0));

        // Saturation: 20 hazard cycles into 4-bit counters
        do_rst();
        drv(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        drv(0, 0, 0, 0);
        chk("sat_st_cnt", 32'(bus.stall_cycles), ecnt(15));
        chk("sat_hz_cnt", 32'(bus.hazard_stalls), ecnt(15));
        drv(1, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0);
        chk("sat_st_hold", 32'(bus.stall_cycles), ecnt(15));
        chk("sat_hz_hold", 32'(bus.hazard_stalls), ecnt(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the stall/flush requests raised around the ARM pipeline: hazard_Detected from the hazard unit, the MEM-stage cache/SRAM wait, and the EXE-stage branch.
- Arbitrates them into per-register freeze, flush and bubble controls.
- Owns a memory-wait FSM with a timeout watchdog, and optional stall performance counters.
- Sits beside the hazard unit at the top level, driving the pipeline registers and the PC.

Parameters:
- TIMEOUT, 255: max consecutive MEM_WAIT cycles before timeout_err is set (1..2^TO_W-1).
- TO_W, 8: width of the watchdog counter.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_Detected  in  1  RAW hazard from the hazard unit (ID stage).
- branch_taken  in  1  EXE-stage branch resolved taken.
- mem_access  in  1  MEM stage holds a load or store (MEM_R_EN|MEM_W_EN).
- mem_ready  in  1  cache/SRAM path completes the access this cycle.
- freeze_pc  out  1  hold the PC.
- freeze_if_id  out  1  hold the IF/ID register.
- freeze_id_exe  out  1  hold the ID/EXE register.
- freeze_exe_mem  out  1  hold the EXE/MEM register.
- bubble_mem_wb  out  1  write a NOP into MEM/WB.
- flush_if_id  out  1  clear the IF/ID register.
- bubble_id_exe  out  1  write a NOP into ID/EXE (clears WB_EN/MEM_EN/B).
- mem_busy  out  1  registered; high while FSM is in MEM_WAIT.
- timeout_err  out  1  registered, sticky; the watchdog expired.
- stall_cycles  out  CNT_W  cycles with freeze_pc high (optional feature).
- hazard_stalls  out  CNT_W  cycles stalled by hazard_Detected (optional feature).

Behaviour:
- Reset (async, rst=1): FSM=RUN, watchdog=0, mem_busy=0, timeout_err=0, counters=0.
- Combinational outputs during reset take the RUN-state decode of the current inputs; this decode is intended to be idle.
- FSM states: RUN, MEM_WAIT.
- RUN -> MEM_WAIT when mem_access=1 and mem_ready=0.
- MEM_WAIT -> RUN when mem_ready=1 or mem_access=0. Dropping mem_access is an abort and is not an error.
- MEM_WAIT self-loops otherwise.
- mem_wait_now = mem_access & ~mem_ready, in either state. This asserts freezes in the same cycle, with zero latency.
- Priority 1, mem_wait_now:
  - freeze_pc, freeze_if_id, freeze_id_exe and freeze_exe_mem are all 1.
  - bubble_mem_wb=1.
  - flush_if_id=0 and bubble_id_exe=0.
  - branch_taken and hazard_Detected are ignored this cycle; they re-evaluate once the pipeline advances.
- Priority 2, branch_taken:
  - flush_if_id=1 and bubble_id_exe=1; all freezes 0.
  - The hazard is ignored because the instruction in ID is squashed.
- Priority 3, hazard_Detected:
  - freeze_pc=1, freeze_if_id=1 and bubble_id_exe=1.
  - freeze_id_exe, freeze_exe_mem and flush_if_id are 0.
- Otherwise all controls are 0.
- The mem_ready rising cycle deasserts freezes in that same cycle, and the FSM returns to RUN on the next edge.
- Watchdog:
  - Cleared in RUN; increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT, timeout_err is set at the next edge and stays set until rst.
  - The counter saturates at TIMEOUT. The FSM keeps waiting, so the pipeline is not released on timeout.
- Simultaneous mem_ready=1 with mem_access=1 in RUN: no stall, the FSM stays in RUN.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- When defined:
  - stall_cycles increments on every edge where freeze_pc=1.
  - hazard_stalls increments when priority 3 is the winning cause.
  - Both saturate at all-ones and do not wrap.
- When undefined: both outputs are constant 0, no counter flops are present, and all other behaviour is identical.

Test Plan:
- Reset mid-MEM_WAIT: assert rst while mem_busy=1 -> mem_busy=0 and timeout_err=0 immediately; with mem_access=1 held and mem_ready=0 after release, freezes=1 in the first cycle.
- Hazard only: hazard_Detected=1 for 2 cycles -> freeze_pc=freeze_if_id=bubble_id_exe=1 both cycles, other outputs 0; hazard_stalls +2 with macro defined.
- Load miss: mem_access=1, mem_ready low for 5 cycles then high -> all 4 freezes and bubble_mem_wb=1 for 5 cycles, 0 in the ready cycle; mem_busy high for 5 cycles starting the cycle after entry; stall_cycles=5.
- Priority clash: mem_wait_now, branch_taken and hazard_Detected all 1 -> memory freezes only, flush_if_id=0; when mem_ready=1 with branch_taken=1 -> flush_if_id=bubble_id_exe=1, no freezes.
- Watchdog: TIMEOUT=4, mem_ready held 0 for 10 cycles -> timeout_err rises after the 4th MEM_WAIT cycle and stays 1 after mem_ready=1; only rst clears it.
- Saturation: CNT_W=4 with macro defined, 20 hazard cycles -> stall_cycles=hazard_stalls=15 and held.
